// File: rtl/tile_renderer_if.sv
// Memory-side bus of the tile renderer: map RAM, tile ROM and player sprite ROM.
// All three memories are synchronous-read with one cycle of latency.
interface tile_renderer_if;
  logic [7:0]  map_addr;
  logic [1:0]  map_data;
  logic [13:0] tile_addr;
  logic [11:0] tile_data;
  logic [11:0] spr_addr;
  logic [11:0] spr_data;

  modport master (
    output map_addr,
    output tile_addr,
    output spr_addr,
    input  map_data,
    input  tile_data,
    input  spr_data
  );

  modport slave (
    input  map_addr,
    input  tile_addr,
    input  spr_addr,
    output map_data,
    output tile_data,
    output spr_data
  );
endinterface

// File: rtl/tile_renderer.sv
// Pixel-colour generator: 64x64 tiles from a 20x12 map with a colour-keyed
// 64x64 player sprite overlaid, fixed 4-cycle coordinate-to-colour latency.
module tile_renderer #(
  parameter int unsigned MAP_COLS    = 20,
  parameter int unsigned MAP_ROWS    = 12,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter logic [11:0] BORDER_RGB  = 12'h222,
  parameter int unsigned LATENCY     = 4
) (
  input  logic             clk84mhz,
  input  logic             rst_n,
  input  logic [10:0]      curr_x,
  input  logic [9:0]       curr_y,
  input  logic [10:0]      player_x,
  input  logic [9:0]       player_y,
  tile_renderer_if.master  mem,
  output logic [3:0]       r_out,
  output logic [3:0]       g_out,
  output logic [3:0]       b_out,
  output logic             frame_start
);

  localparam logic [9:0] BORDER_Y = 10'(MAP_ROWS * 64);
  localparam logic [7:0] COLS8    = 8'(MAP_COLS);

  // Frame detect and player shadow
  logic [10:0] prev_x;
  logic [9:0]  prev_y;
  logic [10:0] shadow_x;
  logic [9:0]  shadow_y;
  logic        frame_hit;

  // Stage-1 combinational terms
  logic [10:0] px_eff;
  logic [9:0]  py_eff;
  logic [11:0] dx;
  logic [11:0] dy;
  logic        in_spr;
  logic        border;
  logic [7:0]  map_idx;

  // Pipeline registers, suffix = edges after the coordinate sample edge
  logic [5:0]  xlo_q0, ylo_q0, xlo_q1, ylo_q1;
  logic        in_q0, in_q1, in_q2, in_q3;
  logic        bd_q0, bd_q1, bd_q2, bd_q3;
  logic [11:0] spr_q2, spr_q3;
  logic [LATENCY-1:0] vld;
  logic [1:0]  tile_type;
  logic [11:0] colour_next;
  logic [11:0] colour_q;

  always_comb begin
    frame_hit = (curr_x == '0) && (curr_y == '0) && !((prev_x == '0) && (prev_y == '0));
  end

  always_ff @(posedge clk84mhz or negedge rst_n) begin
    if (!rst_n) begin
      prev_x      <= '1;
      prev_y      <= '1;
      shadow_x    <= '0;
      shadow_y    <= '0;
      frame_start <= 1'b0;
    end else begin
      prev_x      <= curr_x;
      prev_y      <= curr_y;
      frame_start <= frame_hit;
      if (frame_hit) begin
        shadow_x <= player_x;
        shadow_y <= player_y;
      end
    end
  end

  // The first pixel of a frame bypasses the shadow so the whole frame sees one position.
  always_comb begin
    px_eff  = frame_hit ? player_x : shadow_x;
    py_eff  = frame_hit ? player_y : shadow_y;
    dx      = {1'b0, curr_x} - {1'b0, px_eff};
    dy      = {2'b00, curr_y} - {2'b00, py_eff};
    in_spr  = !dx[11] && (dx[10:6] == '0) && !dy[11] && (dy[10:6] == '0);
    border  = (curr_y >= BORDER_Y);
    map_idx = COLS8 * {4'b0000, curr_y[9:6]} + {3'b000, curr_x[10:6]};
  end

  always_comb begin
    tile_type = (mem.map_data == 2'd3) ? 2'd0 : mem.map_data;
  end

  always_comb begin
    colour_next = '0;
    if (vld[LATENCY-1]) begin
      if (in_q3 && (spr_q3 != TRANSPARENT)) begin
        colour_next = spr_q3;
      end else if (bd_q3) begin
        colour_next = BORDER_RGB;
      end else begin
        colour_next = mem.tile_data;
      end
    end
  end

  always_ff @(posedge clk84mhz or negedge rst_n) begin
    if (!rst_n) begin
      mem.map_addr  <= '0;
      mem.spr_addr  <= '0;
      mem.tile_addr <= '0;
      xlo_q0        <= '0;
      ylo_q0        <= '0;
      xlo_q1        <= '0;
      ylo_q1        <= '0;
      in_q0         <= 1'b0;
      in_q1         <= 1'b0;
      in_q2         <= 1'b0;
      in_q3         <= 1'b0;
      bd_q0         <= 1'b0;
      bd_q1         <= 1'b0;
      bd_q2         <= 1'b0;
      bd_q3         <= 1'b0;
      spr_q2        <= '0;
      spr_q3        <= '0;
      vld           <= '0;
      colour_q      <= '0;
    end else begin
      // Sample edge: issue map and sprite reads
      mem.map_addr <= border ? 8'd0 : map_idx;
      mem.spr_addr <= in_spr ? {dy[5:0], dx[5:0]} : 12'd0;
      xlo_q0       <= curr_x[5:0];
      ylo_q0       <= curr_y[5:0];
      in_q0        <= in_spr;
      bd_q0        <= border;

      // Memories register their data on this edge; carry side info alongside
      xlo_q1 <= xlo_q0;
      ylo_q1 <= ylo_q0;
      in_q1  <= in_q0;
      bd_q1  <= bd_q0;

      // Map and sprite data valid: issue tile ROM read
      mem.tile_addr <= {tile_type, ylo_q1, xlo_q1};
      spr_q2        <= mem.spr_data;
      in_q2         <= in_q1;
      bd_q2         <= bd_q1;

      // Tile ROM registers its data on this edge
      spr_q3 <= spr_q2;
      in_q3  <= in_q2;
      bd_q3  <= bd_q2;

      vld      <= {vld[LATENCY-2:0], 1'b1};
      colour_q <= colour_next;
    end
  end

  assign r_out = colour_q[11:8];
  assign g_out = colour_q[7:4];
  assign b_out = colour_q[3:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Randomised scoreboard bench for tile_renderer with behavioural memory models
// and a pixel-level reference model of the tile/sprite/border colour rules.
module tb_tile_renderer;

  logic        clk84mhz = 1'b0;
  logic        rst_n    = 1'b1;
  logic [10:0] curr_x   = '0;
  logic [9:0]  curr_y   = '0;
  logic [10:0] player_x = '0;
  logic [9:0]  player_y = '0;
  logic [3:0]  r_out, g_out, b_out;
  logic        frame_start;

  tile_renderer_if mem ();

  tile_renderer #(
    .MAP_COLS    (20),
    .MAP_ROWS    (12),
    .TRANSPARENT (12'hF0F),
    .BORDER_RGB  (12'h222),
    .LATENCY     (4)
  ) dut (
    .clk84mhz    (clk84mhz),
    .rst_n       (rst_n),
    .curr_x      (curr_x),
    .curr_y      (curr_y),
    .player_x    (player_x),
    .player_y    (player_y),
    .mem         (mem),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .frame_start (frame_start)
  );

  always #6 clk84mhz = ~clk84mhz;

  int cyc = 0;
  always @(posedge clk84mhz) cyc <= cyc + 1;

  int map_ram  [256];
  int tile_rom [16384];
  int spr_rom  [4096];

  always @(posedge clk84mhz) begin
    mem.map_data  <= 2'(map_ram[mem.map_addr]);
    mem.tile_data <= 12'(tile_rom[mem.tile_addr]);
    mem.spr_data  <= 12'(spr_rom[mem.spr_addr]);
  end

  typedef struct {
    int due;
    int a;
    int b;
  } ent_t;

  ent_t qa[$];
  ent_t qt[$];
  ent_t qc[$];

  int checks = 0;
  int passed = 0;
  int zstart = -100;
  int prev_x = 2047, prev_y = 1023;
  int fpx = 0, fpy = 0;
  int gpx = 0, gpy = 0;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic int map_exp(int x, int y);
    return (y >= 768) ? 0 : (y / 64) * 20 + x / 64;
  endfunction

  function automatic int tile_index(int x, int y);
    int t;
    t = map_ram[map_exp(x, y)];
    if (t == 3) t = 0;
    return t * 4096 + (y % 64) * 64 + (x % 64);
  endfunction

  function automatic int exp_rgb(int x, int y, int px, int py);
    int s;
    if (x >= px && x < px + 64 && y >= py && y < py + 64) begin
      s = spr_rom[(y - py) * 64 + (x - px)];
      if (s != 'hF0F) return s;
    end
    if (y >= 768) return 'h222;
    return tile_rom[tile_index(x, y)];
  endfunction

  task automatic drive_now(input int x, input int y);
    bit   hit;
    ent_t e;
    curr_x   = 11'(x);
    curr_y   = 10'(y);
    player_x = 11'(gpx);
    player_y = 10'(gpy);
    hit = (x == 0 && y == 0) && !(prev_x == 0 && prev_y == 0);
    if (hit) begin
      fpx = gpx;
      fpy = gpy;
    end
    prev_x = x;
    prev_y = y;
    e.due = cyc + 1; e.a = map_exp(x, y);             e.b = int'(hit); qa.push_back(e);
    e.due = cyc + 3; e.a = tile_index(x, y);          e.b = 0;         qt.push_back(e);
    e.due = cyc + 5; e.a = exp_rgb(x, y, fpx, fpy);   e.b = 0;         qc.push_back(e);
  endtask

  task automatic pix(input int x, input int y);
    @(negedge clk84mhz);
    drive_now(x, y);
  endtask

  task automatic check_reset_state();
    check("reset_rgb", {r_out, g_out, b_out}, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_map_addr", mem.map_addr, 0);
    check("reset_tile_addr", mem.tile_addr, 0);
    check("reset_spr_addr", mem.spr_addr, 0);
  endtask

  task automatic assert_reset();
    @(posedge clk84mhz);
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    qa.delete();
    qt.delete();
    qc.delete();
    prev_x = 2047;
    prev_y = 1023;
    zstart = -100;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk84mhz);
    rst_n  = 1'b1;
    zstart = cyc + 1;
    drive_now(0, 0);
  endtask

  // Monitor: pops expectations whose due cycle has arrived
  always @(negedge clk84mhz) begin
    ent_t e;
    if (rst_n) begin
      if (cyc >= zstart && cyc < zstart + 4)
        check("rgb_zero_refill", {r_out, g_out, b_out}, 0);
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        check("map_addr_due", e.due, cyc);
        check("map_addr", mem.map_addr, e.a);
        check("frame_start", frame_start, e.b);
      end
      while (qt.size() > 0 && qt[0].due <= cyc) begin
        e = qt.pop_front();
        check("tile_addr", mem.tile_addr, e.a);
      end
      while (qc.size() > 0 && qc[0].due <= cyc) begin
        e = qc.pop_front();
        check("rgb", {r_out, g_out, b_out}, e.a);
      end
    end
  end

  initial begin
    int x, y, r;
    for (int i = 0; i < 256; i++)   map_ram[i]  = (i < 240) ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i < 16384; i++) tile_rom[i] = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++)
      spr_rom[i] = ($urandom_range(0, 3) == 0) ? 'hF0F : int'($urandom_range(0, 4095));
    map_ram[43]          = 1;
    map_ram[5 * 20 + 5]  = 3;
    spr_rom[10 * 64 + 10] = 'hF0F;
    spr_rom[10 * 64 + 11] = 'h0A0;
    spr_rom[10 * 64 + 63] = 'h123;

    #1 rst_n = 1'b0;
    #2 check_reset_state();
    gpx = 100; gpy = 100;
    release_reset();
    pix(1, 0);
    pix(200, 130);
    pix(110, 110);
    pix(111, 110);
    pix(163, 110);
    pix(164, 110);
    pix(40, 780);
    pix(5 * 64 + 7, 5 * 64 + 9);
    // Mid-frame player move must not take effect until the next frame
    gpx = 300;
    pix(310, 110);
    pix(111, 110);
    pix(0, 0);
    pix(0, 0);
    pix(311, 110);
    pix(111, 110);
    // Right-edge clipping
    gpx = 1250; gpy = 10;
    pix(1, 1);
    pix(0, 0);
    for (int i = 1245; i < 1280; i++) pix(i, 12);
    pix(1279, 73);
    pix(1279, 74);
    gpx = 60; gpy = 740;
    pix(0, 0);
    pix(70, 780);
    pix(40, 799);

    for (int n = 0; n < 400; n++) begin
      gpx = int'($urandom_range(0, 1279));
      gpy = int'($urandom_range(0, 799));
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        x = 0; y = 0;
      end else if (r < 55) begin
        x = fpx - 3 + int'($urandom_range(0, 70));
        y = fpy - 3 + int'($urandom_range(0, 70));
        if (x < 0) x = 0;
        if (x > 1279) x = 1279;
        if (y < 0) y = 0;
        if (y > 799) y = 799;
      end else begin
        x = int'($urandom_range(0, 1279));
        y = int'($urandom_range(0, 799));
      end
      pix(x, y);
    end

    pix(500, 300);
    pix(501, 300);
    assert_reset();
    gpx = 400; gpy = 200;
    release_reset();
    pix(410, 210);
    pix(411, 220);
    for (int n = 0; n < 100; n++) begin
      gpx = int'($urandom_range(0, 1279));
      gpy = int'($urandom_range(0, 799));
      pix(fpx + int'($urandom_range(0, 66)) > 1279 ? 1279 : fpx + int'($urandom_range(0, 66)),
          int'($urandom_range(0, 799)));
    end

    repeat (8) @(negedge clk84mhz);
    #1 check("drain", qa.size() + qt.size() + qc.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
